// File: rtl/noc_intr_pkt_gen_pkg.sv
// Shared constants for the interrupt-packet generator: flit-1 field layout,
// broadcast ID, descriptor geometry and serialiser state encoding.
package noc_intr_pkg;

    // Header flit layout (64-bit NoC header, fields above bit 13)
    localparam int MSG_DST_X_HI  = 49;
    localparam int MSG_DST_X_LO  = 42;
    localparam int MSG_DST_Y_HI  = 41;
    localparam int MSG_DST_Y_LO  = 34;
    localparam int NOC_FBITS_HI  = 33;
    localparam int NOC_FBITS_LO  = 30;
    localparam int MSG_LENGTH_HI = 29;
    localparam int MSG_LENGTH_LO = 22;
    localparam int MSG_TYPE_HI   = 21;
    localparam int MSG_TYPE_LO   = 14;
    localparam int MSG_DST_X_W   = MSG_DST_X_HI - MSG_DST_X_LO + 1;
    localparam int MSG_DST_Y_W   = MSG_DST_Y_HI - MSG_DST_Y_LO + 1;

    localparam logic [3:0] NOC_FBITS_L1       = 4'b0000;
    localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'd60;
    localparam logic [7:0] INTR_MSG_LENGTH    = 8'd1;

    localparam logic [63:0] INTR_BCAST_ID = '1;

    // Descriptor = {tileid, payload, vec}
    localparam int DESC_PAYLOAD_W = 48;
    localparam int DESC_VEC_W     = 9;
    localparam int DESC_EXTRA_W   = DESC_PAYLOAD_W + DESC_VEC_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } intr_state_e;

    function automatic int desc_width(input int tileid_w);
        return tileid_w + DESC_EXTRA_W;
    endfunction

endpackage

// File: rtl/noc_intr_pkt_gen_if.sv
// Request and NoC-injection signals of the interrupt-packet generator.
// The slave modport is the generator's view, master is the environment's.
interface noc_intr_pkt_gen_if #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int TILEID_WIDTH   = 32,
    parameter int FIFO_DEPTH     = 8
);
    logic                          req_val;
    logic                          req_rdy;
    logic [TILEID_WIDTH-1:0]       req_tileid;
    logic [47:0]                   req_payload;
    logic [8:0]                    req_vec;
    logic                          noc_out_val;
    logic                          noc_out_rdy;
    logic [NOC_DATA_WIDTH-1:0]     noc_out_data;
    logic                          err_bad_tile;
    logic [7:0]                    drop_cnt;
    logic [$clog2(FIFO_DEPTH):0]   occupancy;

    modport master (
        output req_val, req_tileid, req_payload, req_vec, noc_out_rdy,
        input  req_rdy, noc_out_val, noc_out_data, err_bad_tile, drop_cnt, occupancy
    );

    modport slave (
        input  req_val, req_tileid, req_payload, req_vec, noc_out_rdy,
        output req_rdy, noc_out_val, noc_out_data, err_bad_tile, drop_cnt, occupancy
    );
endinterface

// File: rtl/noc_intr_pkt_gen_fifo.sv
// Descriptor FIFO with wrap-bit pointers; exposes the head entry and a peek
// at the upper PEEK_W bits of the entry behind it.
module intr_req_fifo #(
    parameter int WIDTH  = 89,
    parameter int DEPTH  = 8,
    parameter int PEEK_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [PEEK_W-1:0]      rd_peek_nxt,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [AW-1:0] IDX_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    rd_idx_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign rd_idx_nxt  = rd_ptr[AW-1:0] + IDX_ONE;
    assign rd_peek_nxt = mem[rd_idx_nxt][WIDTH-1 -: PEEK_W];

endmodule

// File: rtl/noc_intr_pkt_gen.sv
// Interrupt-packet generator: buffers requests and serialises each into a
// two-flit interrupt packet; an all-ones tile ID fans out to every tile.
module noc_intr_pkt_gen
    import noc_intr_pkg::*;
#(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int NOC_X_WIDTH    = 8,
    parameter int NOC_Y_WIDTH    = 8,
    parameter int NUM_TILES_X    = 4,
    parameter int NUM_TILES_Y    = 4,
    parameter int TILEID_WIDTH   = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_intr_pkt_gen_if.slave    bus
);
    localparam int NUM_TILES = NUM_TILES_X * NUM_TILES_Y;
    localparam int TC_W      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int DESC_W    = desc_width(TILEID_WIDTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TILEID_WIDTH-1:0] BCAST_ID  = INTR_BCAST_ID[TILEID_WIDTH-1:0];
    localparam logic [TILEID_WIDTH-1:0] TILE_LIM  = TILEID_WIDTH'(NUM_TILES);
    localparam logic [TC_W-1:0]         TC_LAST   = TC_W'(NUM_TILES - 1);
    localparam logic [TC_W-1:0]         TC_ONE    = 1;
    localparam logic [CNT_W-1:0]        CNT_ONE   = 1;

    logic                      req_fire;
    logic                      req_bcast;
    logic                      req_ok;
    logic                      push;
    logic                      pop;
    logic [DESC_W-1:0]         wr_desc;
    logic [DESC_W-1:0]         head;
    logic [TILEID_WIDTH-1:0]   head_nxt_tileid;
    logic [TILEID_WIDTH-1:0]   head_tileid;
    logic [DESC_PAYLOAD_W-1:0] head_payload;
    logic [DESC_VEC_W-1:0]     head_vec;
    logic                      head_bcast;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;

    intr_state_e               state_q, state_d;
    logic [TC_W-1:0]           tc_q, tc_d;

    logic [NOC_X_WIDTH-1:0]    dst_x;
    logic [NOC_Y_WIDTH-1:0]    dst_y;
    logic [31:0]               tc_ext;
    logic [NOC_DATA_WIDTH-1:0] flit1;
    logic [NOC_DATA_WIDTH-1:0] flit2;

    logic                      err_q;
    logic [7:0]                drop_q;

    function automatic logic [TC_W-1:0] start_tc(input logic [TILEID_WIDTH-1:0] id);
        if (id == BCAST_ID)
            return '0;
        return TC_W'(id);
    endfunction

    assign req_fire  = bus.req_val && bus.req_rdy;
    assign req_bcast = (bus.req_tileid == BCAST_ID);
    assign req_ok    = req_bcast || (bus.req_tileid < TILE_LIM);
    assign push      = req_fire && req_ok;
    assign wr_desc   = {bus.req_tileid, bus.req_payload, bus.req_vec};

    assign bus.req_rdy   = !fifo_full;
    assign bus.occupancy = fifo_count;

    intr_req_fifo #(
        .WIDTH  (DESC_W),
        .DEPTH  (FIFO_DEPTH),
        .PEEK_W (TILEID_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .wr_data     (wr_desc),
        .pop         (pop),
        .rd_data     (head),
        .rd_peek_nxt (head_nxt_tileid),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    assign head_tileid  = head[DESC_W-1:DESC_EXTRA_W];
    assign head_payload = head[DESC_EXTRA_W-1:DESC_VEC_W];
    assign head_vec     = head[DESC_VEC_W-1:0];
    assign head_bcast   = (head_tileid == BCAST_ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end

    // A request arriving into an empty FIFO is picked up from the write port
    // so its header appears the very next cycle; the same trick avoids a
    // bubble when the last entry is popped while a new one is written.
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_HDR;
                    tc_d    = start_tc(head_tileid);
                end else if (push) begin
                    state_d = ST_HDR;
                    tc_d    = start_tc(bus.req_tileid);
                end
            end
            ST_HDR: begin
                if (bus.noc_out_rdy)
                    state_d = ST_BODY;
            end
            ST_BODY: begin
                if (bus.noc_out_rdy) begin
                    if (head_bcast && (tc_q != TC_LAST)) begin
                        tc_d    = tc_q + TC_ONE;
                        state_d = ST_HDR;
                    end else begin
                        pop = 1'b1;
                        if (fifo_count > CNT_ONE) begin
                            state_d = ST_HDR;
                            tc_d    = start_tc(head_nxt_tileid);
                        end else if (push) begin
                            state_d = ST_HDR;
                            tc_d    = start_tc(bus.req_tileid);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tc_ext = 32'(tc_q);
    assign dst_x  = NOC_X_WIDTH'(tc_ext % NUM_TILES_X);
    assign dst_y  = NOC_Y_WIDTH'(tc_ext / NUM_TILES_X);

    always_comb begin
        flit1 = '0;
        flit1[MSG_DST_X_HI:MSG_DST_X_LO]   = MSG_DST_X_W'(dst_x);
        flit1[MSG_DST_Y_HI:MSG_DST_Y_LO]   = MSG_DST_Y_W'(dst_y);
        flit1[NOC_FBITS_HI:NOC_FBITS_LO]   = NOC_FBITS_L1;
        flit1[MSG_LENGTH_HI:MSG_LENGTH_LO] = INTR_MSG_LENGTH;
        flit1[MSG_TYPE_HI:MSG_TYPE_LO]     = MSG_TYPE_INTERRUPT;
    end

    always_comb begin
        flit2       = '0;
        flit2[63:0] = {head_payload, 7'b0, head_vec};
    end

    // Outputs depend only on registered state, so they hold during a stall
    always_comb begin
        bus.noc_out_val  = 1'b0;
        bus.noc_out_data = '0;
        case (state_q)
            ST_HDR: begin
                bus.noc_out_val  = 1'b1;
                bus.noc_out_data = flit1;
            end
            ST_BODY: begin
                bus.noc_out_val  = 1'b1;
                bus.noc_out_data = flit2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else if (req_fire && !req_ok) begin
            err_q <= 1'b1;
            if (drop_q != 8'hFF)
                drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.err_bad_tile = err_q;
    assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_noc_intr_pkt_gen.sv
// Self-checking bench for noc_intr_pkt_gen: directed scenarios plus a random
// run, all scored against a packet-level model of the request stream.
module tb_noc_intr_pkt_gen;
    import noc_intr_pkg::*;

    localparam int NX    = 4;
    localparam int NY    = 4;
    localparam int NT    = NX * NY;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    noc_intr_pkt_gen_if #(.NOC_DATA_WIDTH(64), .TILEID_WIDTH(32), .FIFO_DEPTH(DEPTH)) bus ();

    noc_intr_pkt_gen #(
        .NOC_DATA_WIDTH (64),
        .NOC_X_WIDTH    (8),
        .NOC_Y_WIDTH    (8),
        .NUM_TILES_X    (NX),
        .NUM_TILES_Y    (NY),
        .TILEID_WIDTH   (32),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          model_drop = 0;
    bit          model_err  = 1'b0;

    function automatic logic [63:0] hdr_flit(input int tile);
        logic [63:0] f;
        f        = '0;
        f[49:42] = 8'(tile % NX);
        f[41:34] = 8'(tile / NX);
        f[33:30] = NOC_FBITS_L1;
        f[29:22] = 8'd1;
        f[21:14] = MSG_TYPE_INTERRUPT;
        return f;
    endfunction

    function automatic logic [63:0] body_flit(input logic [47:0] p, input logic [8:0] v);
        return {p, 7'b0, v};
    endfunction

    // Packet-level model of one accepted request
    function automatic void model_request(input logic [31:0] id, input logic [47:0] p, input logic [8:0] v);
        if (id == 32'hFFFF_FFFF) begin
            for (int t = 0; t < NT; t++) begin
                exp_q.push_back(hdr_flit(t));
                exp_q.push_back(body_flit(p, v));
            end
        end else if (id < NT) begin
            exp_q.push_back(hdr_flit(int'(id)));
            exp_q.push_back(body_flit(p, v));
        end else begin
            model_err = 1'b1;
            if (model_drop < 255)
                model_drop++;
        end
    endfunction

    // Handshakes are observed mid-cycle, where inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.noc_out_val && bus.noc_out_rdy)
                got_q.push_back(bus.noc_out_data);
            if (bus.req_val && bus.req_rdy)
                model_request(bus.req_tileid, bus.req_payload, bus.req_vec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] id, input logic [47:0] p, input logic [8:0] v);
        bus.req_val     = 1'b1;
        bus.req_tileid  = id;
        bus.req_payload = p;
        bus.req_vec     = v;
        tick();
        bus.req_val = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            if (!bus.noc_out_val && bus.occupancy == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.noc_out_val !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_val: got %b want 0", bus.noc_out_val); end
        n_checks++; if (bus.noc_out_data !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", bus.noc_out_data); end
        n_checks++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_occ: got %0d want 0", bus.occupancy); end
        n_checks++; if (bus.err_bad_tile !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_bad_tile); end
        n_checks++; if (bus.drop_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b want 1", bus.req_rdy); end
        n_checks++; if (bus.noc_out_val !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_val: got %b want 0", bus.noc_out_val); end
    endtask

    task automatic test_unicast();
        bit ok;
        bus.noc_out_rdy = 1'b1;
        send_req(32'd6, 48'hABCD_0000_1234, 9'h1F5);
        n_checks++; if (bus.noc_out_val !== 1'b1) begin n_fail++; $display("[TB] FAIL uni_hdr_latency: val %b want 1", bus.noc_out_val); end
        n_checks++; if (bus.noc_out_data[49:42] !== 8'd2) begin n_fail++; $display("[TB] FAIL uni_dst_x: got %0d want 2", bus.noc_out_data[49:42]); end
        n_checks++; if (bus.noc_out_data[41:34] !== 8'd1) begin n_fail++; $display("[TB] FAIL uni_dst_y: got %0d want 1", bus.noc_out_data[41:34]); end
        n_checks++; if (bus.noc_out_data[21:14] !== MSG_TYPE_INTERRUPT) begin n_fail++; $display("[TB] FAIL uni_type: got %h want %h", bus.noc_out_data[21:14], MSG_TYPE_INTERRUPT); end
        n_checks++; if (bus.noc_out_data[29:22] !== 8'd1) begin n_fail++; $display("[TB] FAIL uni_len: got %0d want 1", bus.noc_out_data[29:22]); end
        n_checks++; if (bus.noc_out_data !== hdr_flit(6)) begin n_fail++; $display("[TB] FAIL uni_hdr: got %h want %h", bus.noc_out_data, hdr_flit(6)); end
        tick();
        n_checks++; if (bus.noc_out_data !== 64'hABCD_0000_1234_01F5) begin n_fail++; $display("[TB] FAIL uni_body: got %h want abcd0000123401f5", bus.noc_out_data); end
        tick();
        n_checks++; if (bus.noc_out_val !== 1'b0 || bus.noc_out_data !== 64'd0) begin n_fail++; $display("[TB] FAIL uni_idle: val %b data %h want 0/0", bus.noc_out_val, bus.noc_out_data); end
        wait_idle(20, ok);
        n_checks++; if (got_q.size() != exp_q.size() || !ok) begin n_fail++; $display("[TB] FAIL uni_count: got %0d flits want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL uni_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [47:0] p;
        p = 48'h1357_9BDF_0246;
        bus.noc_out_rdy = 1'b0;
        send_req(32'd9, p, 9'h0A5);
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.noc_out_val !== 1'b1 || bus.noc_out_data !== hdr_flit(9)) begin n_fail++; $display("[TB] FAIL bp_hold%0d: val %b data %h want 1/%h", k, bus.noc_out_val, bus.noc_out_data, hdr_flit(9)); end
            tick();
        end
        bus.noc_out_rdy = 1'b1;
        tick();
        n_checks++; if (bus.noc_out_data !== body_flit(p, 9'h0A5)) begin n_fail++; $display("[TB] FAIL bp_body: got %h want %h", bus.noc_out_data, body_flit(p, 9'h0A5)); end
        tick();
        n_checks++; if (bus.noc_out_val !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_idle: val %b want 0", bus.noc_out_val); end
        wait_idle(20, ok);
        n_checks++; if (got_q.size() != 2 || !ok) begin n_fail++; $display("[TB] FAIL bp_count: got %0d flits want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL bp_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill_overflow();
        bit ok;
        logic [63:0] r;
        bus.noc_out_rdy = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            r = {$urandom(), $urandom()};
            bus.req_val     = 1'b1;
            bus.req_tileid  = 32'(i + 3);
            bus.req_payload = r[47:0];
            bus.req_vec     = r[56:48];
            @(negedge clk);
            n_checks++; if (bus.req_rdy !== (i < DEPTH)) begin n_fail++; $display("[TB] FAIL fill_rdy%0d: got %b want %b", i, bus.req_rdy, (i < DEPTH)); end
            tick();
        end
        bus.req_val = 1'b0;
        n_checks++; if (bus.occupancy !== 4'd8) begin n_fail++; $display("[TB] FAIL fill_occ: got %0d want 8", bus.occupancy); end
        n_checks++; if (bus.req_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_full_rdy: got %b want 0", bus.req_rdy); end
        bus.noc_out_rdy = 1'b1;
        wait_idle(100, ok);
        n_checks++; if (got_q.size() != 16 || exp_q.size() != 16 || !ok) begin n_fail++; $display("[TB] FAIL fill_count: got %0d flits want 16 (model %0d)", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL fill_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_broadcast();
        bit ok;
        bus.noc_out_rdy = 1'b1;
        send_req(32'hFFFF_FFFF, 48'h0000_CAFE_F00D, 9'h100);
        wait_idle(100, ok);
        n_checks++; if (got_q.size() != 2 * NT || !ok) begin n_fail++; $display("[TB] FAIL bcast_count: got %0d flits want %0d", got_q.size(), 2 * NT); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL bcast_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.noc_out_val !== 1'b0) begin n_fail++; $display("[TB] FAIL bcast_idle: val %b want 0", bus.noc_out_val); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_bad_id();
        bus.noc_out_rdy = 1'b1;
        send_req(32'd16, 48'h1111_2222_3333, 9'h044);
        repeat (3) tick();
        n_checks++; if (bus.noc_out_val !== 1'b0 || got_q.size() != 0) begin n_fail++; $display("[TB] FAIL bad_no_output: val %b flits %0d want 0/0", bus.noc_out_val, got_q.size()); end
        n_checks++; if (bus.err_bad_tile !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_err: got %b want 1", bus.err_bad_tile); end
        n_checks++; if (bus.drop_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL bad_drop1: got %0d want 1", bus.drop_cnt); end
        for (int i = 0; i < 300; i++) begin
            bus.req_val    = 1'b1;
            bus.req_tileid = 32'($urandom_range(16, 5000));
            tick();
        end
        bus.req_val = 1'b0;
        tick();
        n_checks++; if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("[TB] FAIL bad_drop_sat: got %0d want 255", bus.drop_cnt); end
        n_checks++; if (int'(bus.drop_cnt) != model_drop) begin n_fail++; $display("[TB] FAIL bad_drop_model: got %0d want %0d", bus.drop_cnt, model_drop); end
        n_checks++; if (got_q.size() != 0 || bus.occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL bad_no_write: flits %0d occ %0d want 0/0", got_q.size(), bus.occupancy); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        bus.noc_out_rdy = 1'b0;
        send_req(32'd3, 48'hDEAD_BEEF_0001, 9'h003);
        send_req(32'd5, 48'hDEAD_BEEF_0002, 9'h005);
        bus.noc_out_rdy = 1'b1;
        tick();
        bus.noc_out_rdy = 1'b0;
        n_checks++; if (bus.noc_out_data !== body_flit(48'hDEAD_BEEF_0001, 9'h003)) begin n_fail++; $display("[TB] FAIL rmid_body: got %h want %h", bus.noc_out_data, body_flit(48'hDEAD_BEEF_0001, 9'h003)); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.noc_out_val !== 1'b0 || bus.noc_out_data !== 64'd0) begin n_fail++; $display("[TB] FAIL rmid_val: val %b data %h want 0/0", bus.noc_out_val, bus.noc_out_data); end
        n_checks++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("[TB] FAIL rmid_occ: got %0d want 0", bus.occupancy); end
        n_checks++; if (bus.err_bad_tile !== 1'b0 || bus.drop_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL rmid_err: err %b drop %0d want 0/0", bus.err_bad_tile, bus.drop_cnt); end
        got_q.delete(); exp_q.delete();
        model_drop = 0;
        model_err  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.noc_out_val !== 1'b0) begin n_fail++; $display("[TB] FAIL rmid_post_val: val %b want 0", bus.noc_out_val); end
        bus.noc_out_rdy = 1'b1;
        send_req(32'd12, 48'h0F0F_0F0F_0F0F, 9'h0C0);
        wait_idle(20, ok);
        n_checks++; if (got_q.size() != 2 || !ok) begin n_fail++; $display("[TB] FAIL rmid_count: got %0d flits want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rmid_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit          ok;
        bit          held;
        logic [63:0] held_data;
        logic [63:0] r;
        int          sel;
        held = 1'b0;
        held_data = '0;
        for (int c = 0; c < 600; c++) begin
            r   = {$urandom(), $urandom()};
            sel = $urandom_range(0, 19);
            bus.req_val     = ($urandom_range(0, 2) == 0);
            bus.req_payload = r[47:0];
            bus.req_vec     = r[56:48];
            if (sel < 15)       bus.req_tileid = 32'($urandom_range(0, NT - 1));
            else if (sel == 15) bus.req_tileid = 32'hFFFF_FFFF;
            else                bus.req_tileid = 32'($urandom_range(NT, 100000));
            bus.noc_out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held) begin
                n_checks++; if (bus.noc_out_val !== 1'b1 || bus.noc_out_data !== held_data) begin n_fail++; $display("[TB] FAIL rnd_stable@%0d: val %b data %h want 1/%h", c, bus.noc_out_val, bus.noc_out_data, held_data); end
            end
            if (!bus.noc_out_val) begin
                n_checks++; if (bus.noc_out_data !== 64'd0) begin n_fail++; $display("[TB] FAIL rnd_zero@%0d: data %h want 0", c, bus.noc_out_data); end
            end
            held      = bus.noc_out_val && !bus.noc_out_rdy;
            held_data = bus.noc_out_data;
            tick();
        end
        bus.req_val     = 1'b0;
        bus.noc_out_rdy = 1'b1;
        wait_idle(2000, ok);
        n_checks++; if (got_q.size() != exp_q.size() || !ok) begin n_fail++; $display("[TB] FAIL rnd_count: got %0d flits want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rnd_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (int'(bus.drop_cnt) != model_drop) begin n_fail++; $display("[TB] FAIL rnd_drop: got %0d want %0d", bus.drop_cnt, model_drop); end
        n_checks++; if (bus.err_bad_tile !== model_err) begin n_fail++; $display("[TB] FAIL rnd_err: got %b want %b", bus.err_bad_tile, model_err); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.req_val     = 1'b0;
        bus.req_tileid  = '0;
        bus.req_payload = '0;
        bus.req_vec     = '0;
        bus.noc_out_rdy = 1'b0;
        test_reset();
        test_unicast();
        test_backpressure();
        test_fill_overflow();
        test_broadcast();
        test_bad_id();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/noc_intr_pkt_gen.md
# noc_intr_pkt_gen

Parametrised interrupt-packet generator that sits between an on-chip interrupt source and the NoC injection port. It accepts interrupt requests (target tile ID, payload, vector), buffers them in a bounded descriptor FIFO with back-pressure, and serialises each request into a two-flit `MSG_TYPE_INTERRUPT` packet addressed to the tile's mesh (x, y). Mesh size, FIFO depth and ID widths are parameters. An all-ones tile ID is a broadcast and expands into one packet per tile; out-of-range IDs are dropped and flagged.

## Interface
- `NOC_DATA_WIDTH`, 64: flit width; must be ≥ 64.
- `NOC_X_WIDTH`, 8: width of the destination-X field.
- `NOC_Y_WIDTH`, 8: width of the destination-Y field.
- `NUM_TILES_X`, 4: mesh columns.
- `NUM_TILES_Y`, 4: mesh rows.
- `TILEID_WIDTH`, 32: width of the request tile ID.
- `FIFO_DEPTH`, 8: descriptor entries; must be a power of 2 and ≥ 2.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_val`  in  1  request valid.
- `req_rdy`  out  1  request ready; equals FIFO not full.
- `req_tileid`  in  TILEID_WIDTH  target tile; all-ones means broadcast.
- `req_payload`  in  48  goes to flit2[63:16].
- `req_vec`  in  9  goes to flit2[8:0].
- `noc_out_val`  out  1  flit valid.
- `noc_out_rdy`  in  1  flit ready.
- `noc_out_data`  out  NOC_DATA_WIDTH  flit.
- `err_bad_tile`  out  1  sticky flag: an out-of-range unicast ID was dropped.
- `drop_cnt`  out  8  saturating count of dropped requests.
- `occupancy`  out  $clog2(FIFO_DEPTH)+1  FIFO entry count.

## Operation
- **Enqueue:** occurs when `req_val && req_rdy`.
  - Tile ID < NUM_TILES_X*NUM_TILES_Y, or broadcast: write {tileid, payload, vec} to the FIFO.
  - Otherwise: do not write. Set `err_bad_tile`; increment `drop_cnt` (saturates at 255).
- **Serialiser FSM:** states IDLE, HDR, BODY.
  - IDLE → HDR when the FIFO is non-empty. Load the head entry. The tile counter `tc` starts at the ID, or at 0 for broadcast.
  - HDR: drive flit1 and hold it until `noc_out_rdy`, then go to BODY.
  - BODY: drive flit2 and hold it until `noc_out_rdy`.
    - Broadcast and `tc` < N-1: increment `tc`, go to HDR.
    - Otherwise: pop the FIFO. Go to HDR if another entry is present (no bubble), else IDLE.
- **Flit1:**
  - Zero, then insert the fields: `NOC_FBITS_L1`, length 8'd1, `MSG_TYPE_INTERRUPT`, 14'b0 low bits.
  - `MSG_DST_X` = `tc` % NUM_TILES_X.
  - `MSG_DST_Y` = `tc` / NUM_TILES_X.
  - Both are truncated to the field widths.
- **Flit2:** {payload, 7'b0, vec}, zero-extended to NOC_DATA_WIDTH.
- **Output data:** `noc_out_data` is 0 whenever `noc_out_val` = 0. It never carries X.
- **Handshake:** once `noc_out_val` is high, `noc_out_val` and `noc_out_data` stay stable until accepted.
- **Arithmetic:** div/mod by parameter constants, evaluated on the `tc` register. FIFO pointers use log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.

## Timing
- **Reset values (`rst` asserted, async):**
  - `noc_out_val` = 0, `noc_out_data` = 0.
  - `req_rdy` = 1 (after reset).
  - `occupancy` = 0, `err_bad_tile` = 0, `drop_cnt` = 0.
  - FSM = IDLE, pointers = 0.
- **Reset mid-packet:** the in-flight packet is abandoned. No partial flit is emitted after deassertion.
- **Latency:** request accepted at cycle N into an empty FIFO → header valid at N+1 → body at N+2 with `noc_out_rdy` held high.
- **Throughput:** one flit per cycle; a unicast packet costs 2 cycles; a broadcast costs 2·NUM_TILES_X·NUM_TILES_Y cycles.
- **Full:** `req_rdy` = 0 when occupancy == FIFO_DEPTH.
- **Simultaneous enqueue and pop while full:**
  - The enqueue is refused that cycle, because `req_rdy` is combinational from registered occupancy only.
  - `req_rdy` rises the next cycle.
- **Simultaneous enqueue and pop, not full:** occupancy is unchanged.
- **Bad-ID request when full:** it is not accepted, so it is not counted.

## Structure
- **Shared package `noc_intr_pkg`:**
  - Flit-1 field offsets (reuse the `MSG_*` and `NOC_FBITS_*` defines).
  - `INTR_BCAST_ID`.
  - FSM state encoding.
  - Descriptor struct width (TILEID_WIDTH+57).
- **Sub-module `intr_req_fifo`:** parametrised synchronous FIFO (width, depth) exposing full, empty and count. The top module holds the FSM, address computation and error logic.

## Test plan
- **Unicast:** reset, then request tileid 6, payload 48'hABCD_0000_1234, vec 9'h1F5. Require:
  - Flit1 DST_X = 2, DST_Y = 1, type interrupt, length 1.
  - Flit2 = 64'hABCD_0000_1234_01F5.
  - Header at cycle N+1.
- **Back-pressure:** hold `noc_out_rdy` = 0 for 5 cycles mid-header, then 1. Require stable flit1 data across the stall, then body, with no duplication.
- **Fill and overflow:** 9 back-to-back requests with `noc_out_rdy` = 0 and FIFO_DEPTH = 8. Require:
  - `req_rdy` drops after the 8th; `occupancy` = 8.
  - After release, exactly 8 packets in order.
- **Broadcast:** tileid 32'hFFFF_FFFF on a 4×4 mesh. Require 16 packets with destinations (0,0),(1,0)…(3,3) in order, then IDLE.
- **Bad ID:** tileid 16. Require no output, `err_bad_tile` = 1, `drop_cnt` = 1. Then 300 bad IDs → `drop_cnt` = 255.
- **Reset mid-packet:** assert `rst` while BODY is stalled. Require `noc_out_val` = 0 immediately, `occupancy` = 0, and only new requests emitted afterwards.
